// File: rtl/cp0_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_defs                                                             |
// | Shared CP0 constants: register addresses, ExcCodes, bit positions.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cp0_defs;

  // CP0 register numbers (rd field of mfc0/mtc0)
  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0A;
  localparam logic [4:0] EXC_OV   = 5'h0C;

  // Status / Cause bit positions
  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int STATUS_IM_HI = 15;
  localparam int STATUS_BEV   = 22;
  localparam int CAUSE_IPSW_LO = 8;
  localparam int CAUSE_IPSW_HI = 9;
  localparam int CAUSE_BD     = 31;

  localparam logic [31:0] EXC_ENTRY_DEFAULT = 32'hBFC0_0380;

  // Source of the faulting address latched into BadVAddr
  typedef enum logic [1:0] {
    BADV_NONE = 2'd0,
    BADV_PC   = 2'd1,
    BADV_ADDR = 2'd2
  } badv_sel_e;

  // Assemble the architectural Status word; BEV is hard-wired to 1
  function automatic logic [31:0] status_pack(input logic [7:0] im,
                                              input logic exl,
                                              input logic ie);
    status_pack = {9'd0, 1'b1, 6'd0, im, 6'd0, exl, ie};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_timer                                                            |
// | Count/Compare timer: Count advances every other cycle, timer_int     |
// | latches on Count == Compare (Compare != 0) until Compare is written. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        timer_int_o
);

  logic        tick_q, tick_d;
  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        timer_int_q, timer_int_d;

  // Next-state: software writes override the half-rate increment; a
  // Compare write acknowledges the interrupt ahead of a same-cycle match
  always_comb begin
    tick_d      = ~tick_q;
    count_d     = count_q;
    compare_d   = compare_q;
    timer_int_d = timer_int_q;
    if (count_we_i)  count_d = wdata_i;
    else if (tick_q) count_d = count_q + 32'd1;
    if (compare_we_i) begin
      compare_d   = wdata_i;
      timer_int_d = 1'b0;
    end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
      timer_int_d = 1'b1;
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q      <= 1'b0;
      count_q     <= 32'd0;
      compare_q   <= 32'd0;
      timer_int_q <= 1'b0;
    end else begin
      tick_q      <= tick_d;
      count_q     <= count_d;
      compare_q   <= compare_d;
      timer_int_q <= timer_int_d;
    end
  end

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign timer_int_o = timer_int_q;

endmodule
`default_nettype wire

// File: rtl/cp0_exception_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cp0_exception_unit                                                   |
// | MEM-stage exception arbiter and CP0 register file (Status, Cause,    |
// | EPC, BadVAddr, Count, Compare) with flush/redirect generation.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cp0_exception_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallM,
  input  logic        validM,
  input  logic        riM,
  input  logic        breakM,
  input  logic        syscallM,
  input  logic        eretM,
  input  logic        overflowM,
  input  logic        adel_fetchM,
  input  logic        adel_dataM,
  input  logic        ades_dataM,
  input  logic        in_delayslotM,
  input  logic [31:0] pcM,
  input  logic [31:0] mem_addrM,
  input  logic        cp0_wenM,
  input  logic [4:0]  cp0_addrM,
  input  logic [31:0] cp0_wdataM,
  input  logic [5:0]  int_i,
  output logic [31:0] cp0_rdataM,
  output logic        exc_flush,
  output logic [31:0] exc_pc,
  output logic [4:0]  exc_code,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  logic [7:0]  im_q;
  logic        exl_q, ie_q;
  logic [5:0]  ip_hw_q;
  logic [1:0]  ip_sw_q;
  logic        bd_q;
  logic [4:0]  exccode_q;
  logic [31:0] epc_q, badvaddr_q;
  logic [31:0] count_w, compare_w;
  logic        timer_int_w;

  logic        commit_w, int_pending_w, exc_hit_w, exc_take_w, eret_take_w, wr_w;
  logic [4:0]  code_w;
  badv_sel_e   badv_sel_w;

  assign commit_w      = validM & ~stallM & ~rst;
  assign int_pending_w = validM & ie_q & ~exl_q & (|({ip_hw_q, ip_sw_q} & im_q));

  // Fixed-priority exception selection, interrupt highest
  always_comb begin
    exc_hit_w  = 1'b1;
    code_w     = EXC_INT;
    badv_sel_w = BADV_NONE;
    if (int_pending_w)    code_w = EXC_INT;
    else if (adel_fetchM) begin code_w = EXC_ADEL; badv_sel_w = BADV_PC;   end
    else if (riM)         code_w = EXC_RI;
    else if (syscallM)    code_w = EXC_SYS;
    else if (breakM)      code_w = EXC_BP;
    else if (overflowM)   code_w = EXC_OV;
    else if (adel_dataM)  begin code_w = EXC_ADEL; badv_sel_w = BADV_ADDR; end
    else if (ades_dataM)  begin code_w = EXC_ADES; badv_sel_w = BADV_ADDR; end
    else                  exc_hit_w = 1'b0;
  end

  assign exc_take_w  = commit_w & exc_hit_w;
  assign eret_take_w = commit_w & ~exc_hit_w & eretM;
  // A taken exception swallows any mtc0 carried by the same instruction
  assign wr_w        = commit_w & cp0_wenM & ~exc_take_w;

  assign exc_flush = exc_take_w | eret_take_w;
  assign exc_pc    = eret_take_w ? epc_q : EXC_ENTRY;
  assign exc_code  = exc_take_w ? code_w : 5'd0;

  cp0_timer u_timer (
    .clk          (clk),
    .rst          (rst),
    .count_we_i   (wr_w && (cp0_addrM == CP0_COUNT)),
    .compare_we_i (wr_w && (cp0_addrM == CP0_COMPARE)),
    .wdata_i      (cp0_wdataM),
    .count_o      (count_w),
    .compare_o    (compare_w),
    .timer_int_o  (timer_int_w)
  );

  // Status/Cause/EPC/BadVAddr: exception entry and eret beat software writes
  always_ff @(posedge clk) begin
    if (rst) begin
      im_q       <= 8'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_hw_q    <= 6'd0;
      ip_sw_q    <= 2'd0;
      bd_q       <= 1'b0;
      exccode_q  <= 5'd0;
      epc_q      <= 32'd0;
      badvaddr_q <= 32'd0;
    end else begin
      ip_hw_q <= {int_i[5] | timer_int_w, int_i[4:0]};
      if (exc_take_w) begin
        exl_q     <= 1'b1;
        exccode_q <= code_w;
        if (!exl_q) begin
          epc_q <= in_delayslotM ? (pcM - 32'd4) : pcM;
          bd_q  <= in_delayslotM;
        end
        if (badv_sel_w == BADV_PC)   badvaddr_q <= pcM;
        if (badv_sel_w == BADV_ADDR) badvaddr_q <= mem_addrM;
      end else if (eret_take_w) begin
        exl_q <= 1'b0;
      end else if (wr_w) begin
        case (cp0_addrM)
          CP0_STATUS: begin
            im_q  <= cp0_wdataM[STATUS_IM_HI:STATUS_IM_LO];
            exl_q <= cp0_wdataM[STATUS_EXL];
            ie_q  <= cp0_wdataM[STATUS_IE];
          end
          CP0_CAUSE: ip_sw_q <= cp0_wdataM[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
          CP0_EPC:   epc_q   <= cp0_wdataM;
          default:   ;
        endcase
      end
    end
  end

  assign status_o    = status_pack(im_q, exl_q, ie_q);
  assign cause_o     = {bd_q, 15'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'b00};
  assign epc_o       = epc_q;
  assign timer_int_o = timer_int_w;

  // mfc0 read mux; unimplemented addresses return 0
  always_comb begin
    case (cp0_addrM)
      CP0_BADVADDR: cp0_rdataM = badvaddr_q;
      CP0_COUNT:    cp0_rdataM = count_w;
      CP0_COMPARE:  cp0_rdataM = compare_w;
      CP0_STATUS:   cp0_rdataM = status_o;
      CP0_CAUSE:    cp0_rdataM = cause_o;
      CP0_EPC:      cp0_rdataM = epc_q;
      default:      cp0_rdataM = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cp0_exception_unit                                                |
// | Directed self-checking bench for the CP0 exception unit.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_cp0_exception_unit;

  logic        clk, rst, stallM, validM, riM, breakM, syscallM, eretM;
  logic        overflowM, adel_fetchM, adel_dataM, ades_dataM, in_delayslotM;
  logic [31:0] pcM, mem_addrM, cp0_wdataM;
  logic        cp0_wenM;
  logic [4:0]  cp0_addrM;
  logic [5:0]  int_i;
  logic [31:0] cp0_rdataM, exc_pc, epc_o, status_o, cause_o;
  logic        exc_flush, timer_int_o;
  logic [4:0]  exc_code;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_exception_unit dut (
    .clk(clk), .rst(rst), .stallM(stallM), .validM(validM),
    .riM(riM), .breakM(breakM), .syscallM(syscallM), .eretM(eretM),
    .overflowM(overflowM), .adel_fetchM(adel_fetchM),
    .adel_dataM(adel_dataM), .ades_dataM(ades_dataM),
    .in_delayslotM(in_delayslotM), .pcM(pcM), .mem_addrM(mem_addrM),
    .cp0_wenM(cp0_wenM), .cp0_addrM(cp0_addrM), .cp0_wdataM(cp0_wdataM),
    .int_i(int_i), .cp0_rdataM(cp0_rdataM), .exc_flush(exc_flush),
    .exc_pc(exc_pc), .exc_code(exc_code), .epc_o(epc_o),
    .status_o(status_o), .cause_o(cause_o), .timer_int_o(timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in;
    validM = 0; stallM = 0; riM = 0; breakM = 0; syscallM = 0; eretM = 0;
    overflowM = 0; adel_fetchM = 0; adel_dataM = 0; ades_dataM = 0;
    in_delayslotM = 0; pcM = 0; mem_addrM = 0;
    cp0_wenM = 0; cp0_addrM = 0; cp0_wdataM = 0;
  endtask

  // Issue one mtc0; returns at the negedge after it has committed
  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk); clear_in;
    validM = 1; cp0_wenM = 1; cp0_addrM = a; cp0_wdataM = d;
    @(negedge clk); clear_in;
  endtask

  task automatic test_reset;
    rst = 1; clear_in; int_i = 0;
    repeat (3) @(negedge clk);
    validM = 1; syscallM = 1; #1;
    n_cmp++; if (exc_flush !== 1'b0) begin n_bad++; $display("FAIL rst_flush got %0b want 0", exc_flush); end
    clear_in; cp0_addrM = 5'd12; #1;
    n_cmp++; if (cp0_rdataM !== 32'h0040_0000) begin n_bad++; $display("FAIL rst_status got %h want 00400000", cp0_rdataM); end
    cp0_addrM = 5'd13; #1;
    n_cmp++; if (cp0_rdataM !== 32'h0) begin n_bad++; $display("FAIL rst_cause got %h want 0", cp0_rdataM); end
    cp0_addrM = 5'd14; #1;
    n_cmp++; if (cp0_rdataM !== 32'h0) begin n_bad++; $display("FAIL rst_epc got %h want 0", cp0_rdataM); end
    cp0_addrM = 5'd9; #1;
    n_cmp++; if (cp0_rdataM !== 32'h0) begin n_bad++; $display("FAIL rst_count got %h want 0", cp0_rdataM); end
    @(negedge clk); rst = 0; clear_in;
  endtask

  task automatic test_syscall;
    @(negedge clk); validM = 1; syscallM = 1; pcM = 32'hBFC0_1000; #1;
    n_cmp++; if (exc_flush !== 1'b1) begin n_bad++; $display("FAIL sys_flush got %0b want 1", exc_flush); end
    n_cmp++; if (exc_pc !== 32'hBFC0_0380) begin n_bad++; $display("FAIL sys_pc got %h want bfc00380", exc_pc); end
    n_cmp++; if (exc_code !== 5'h08) begin n_bad++; $display("FAIL sys_code got %h want 08", exc_code); end
    @(negedge clk); clear_in; #1;
    n_cmp++; if (epc_o !== 32'hBFC0_1000) begin n_bad++; $display("FAIL sys_epc got %h want bfc01000", epc_o); end
    n_cmp++; if (status_o !== 32'h0040_0002) begin n_bad++; $display("FAIL sys_status got %h want 00400002", status_o); end
    n_cmp++; if (cause_o !== 32'h0000_0020) begin n_bad++; $display("FAIL sys_cause got %h want 00000020", cause_o); end
  endtask

  task automatic test_ades_eret;
    @(negedge clk); validM = 1; eretM = 1; #1;
    n_cmp++; if (exc_flush !== 1'b1 || exc_pc !== 32'hBFC0_1000) begin n_bad++; $display("FAIL eret1_pc got %0b/%h want 1/bfc01000", exc_flush, exc_pc); end
    n_cmp++; if (exc_code !== 5'h00) begin n_bad++; $display("FAIL eret1_code got %h want 00", exc_code); end
    @(negedge clk); clear_in; #1;
    n_cmp++; if (status_o !== 32'h0040_0000) begin n_bad++; $display("FAIL eret1_status got %h want 00400000", status_o); end
    @(negedge clk);
    validM = 1; ades_dataM = 1; in_delayslotM = 1; pcM = 32'h8000_0024; mem_addrM = 32'h8000_1001; #1;
    n_cmp++; if (exc_code !== 5'h05) begin n_bad++; $display("FAIL ades_code got %h want 05", exc_code); end
    @(negedge clk); clear_in; #1;
    n_cmp++; if (epc_o !== 32'h8000_0020) begin n_bad++; $display("FAIL ades_epc got %h want 80000020", epc_o); end
    n_cmp++; if (cause_o !== 32'h8000_0014) begin n_bad++; $display("FAIL ades_cause got %h want 80000014", cause_o); end
    cp0_addrM = 5'd8; #1;
    n_cmp++; if (cp0_rdataM !== 32'h8000_1001) begin n_bad++; $display("FAIL ades_badv got %h want 80001001", cp0_rdataM); end
    @(negedge clk); clear_in; validM = 1; eretM = 1; #1;
    n_cmp++; if (exc_pc !== 32'h8000_0020) begin n_bad++; $display("FAIL eret2_pc got %h want 80000020", exc_pc); end
    @(negedge clk); clear_in; #1;
    n_cmp++; if (status_o !== 32'h0040_0000) begin n_bad++; $display("FAIL eret2_status got %h want 00400000", status_o); end
    n_cmp++; if (cause_o !== 32'h8000_0014) begin n_bad++; $display("FAIL eret2_cause got %h want 80000014", cause_o); end
  endtask

  task automatic test_interrupt;
    mtc0(5'd12, 32'h0000_0401); #1;
    n_cmp++; if (status_o !== 32'h0040_0401) begin n_bad++; $display("FAIL int_status got %h want 00400401", status_o); end
    int_i = 6'b000001;
    @(negedge clk); #1;
    n_cmp++; if (cause_o !== 32'h8000_0414) begin n_bad++; $display("FAIL int_ip got %h want 80000414", cause_o); end
    validM = 1; riM = 1; cp0_wenM = 1; cp0_addrM = 5'd11; cp0_wdataM = 32'd5; #1;
    n_cmp++; if (exc_flush !== 1'b1 || exc_code !== 5'h00) begin n_bad++; $display("FAIL int_code got %0b/%h want 1/00", exc_flush, exc_code); end
    @(negedge clk); clear_in; int_i = 0; #1;
    n_cmp++; if (status_o !== 32'h0040_0403) begin n_bad++; $display("FAIL int_exl got %h want 00400403", status_o); end
    n_cmp++; if (cause_o !== 32'h0000_0400) begin n_bad++; $display("FAIL int_cause got %h want 00000400", cause_o); end
    cp0_addrM = 5'd11; #1;
    n_cmp++; if (cp0_rdataM !== 32'h0) begin n_bad++; $display("FAIL int_mtc0_discard got %h want 0", cp0_rdataM); end
    @(negedge clk); clear_in; validM = 1; eretM = 1;
    @(negedge clk); clear_in;
    mtc0(5'd12, 32'h0);
  endtask

  task automatic test_timer;
    bit found = 0;
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd10); #1;
    n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL tmr_early got %0b want 0", timer_int_o); end
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (timer_int_o === 1'b1) found = 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL tmr_rise got 0 want 1 within 60 cycles"); end
    @(negedge clk); #1;
    n_cmp++; if (cause_o[15] !== 1'b1) begin n_bad++; $display("FAIL tmr_ip15 got %0b want 1", cause_o[15]); end
    mtc0(5'd11, 32'd50); #1;
    n_cmp++; if (timer_int_o !== 1'b0) begin n_bad++; $display("FAIL tmr_clear got %0b want 0", timer_int_o); end
    mtc0(5'd9, 32'hFFFF_FFFF);
    cp0_addrM = 5'd9; #1;
    n_cmp++; if (cp0_rdataM !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL tmr_cnt_wr got %h want ffffffff", cp0_rdataM); end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (cp0_rdataM !== 32'h0) begin n_bad++; $display("FAIL tmr_wrap got %h want 0", cp0_rdataM); end
    clear_in;
  endtask

  task automatic test_stall;
    @(negedge clk); validM = 1; stallM = 1; breakM = 1; pcM = 32'h8000_0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (exc_flush !== 1'b0 || exc_code !== 5'h00) begin n_bad++; $display("FAIL stall_hold%0d got %0b/%h want 0/00", i, exc_flush, exc_code); end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (status_o !== 32'h0040_0000) begin n_bad++; $display("FAIL stall_exl got %h want 00400000", status_o); end
    stallM = 0; #1;
    n_cmp++; if (exc_flush !== 1'b1 || exc_code !== 5'h09) begin n_bad++; $display("FAIL stall_take got %0b/%h want 1/09", exc_flush, exc_code); end
    @(negedge clk); clear_in; #1;
    n_cmp++; if (exc_flush !== 1'b0) begin n_bad++; $display("FAIL stall_once got %0b want 0", exc_flush); end
    n_cmp++; if (epc_o !== 32'h8000_0100) begin n_bad++; $display("FAIL stall_epc got %h want 80000100", epc_o); end
    n_cmp++; if (cause_o !== 32'h0000_0024) begin n_bad++; $display("FAIL stall_cause got %h want 00000024", cause_o); end
  endtask

  task automatic test_priority;
    @(negedge clk); validM = 1; riM = 1; syscallM = 1; pcM = 32'h8000_0200; #1;
    n_cmp++; if (exc_code !== 5'h0A) begin n_bad++; $display("FAIL pri_ri got %h want 0a", exc_code); end
    @(negedge clk); clear_in; #1;
    n_cmp++; if (epc_o !== 32'h8000_0100) begin n_bad++; $display("FAIL pri_epc_keep got %h want 80000100", epc_o); end
    validM = 1; overflowM = 1; adel_dataM = 1; mem_addrM = 32'h0000_0003; #1;
    n_cmp++; if (exc_code !== 5'h0C) begin n_bad++; $display("FAIL pri_ov got %h want 0c", exc_code); end
    @(negedge clk); clear_in;
    validM = 1; adel_fetchM = 1; riM = 1; pcM = 32'h8000_0302; #1;
    n_cmp++; if (exc_code !== 5'h04) begin n_bad++; $display("FAIL pri_adelf got %h want 04", exc_code); end
    @(negedge clk); clear_in; cp0_addrM = 5'd8; #1;
    n_cmp++; if (cp0_rdataM !== 32'h8000_0302) begin n_bad++; $display("FAIL pri_badv got %h want 80000302", cp0_rdataM); end
    clear_in;
  endtask

  task automatic test_reset_mid;
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    n_cmp++; if (status_o !== 32'h0040_0000 || epc_o !== 32'h0 || cause_o !== 32'h0) begin
      n_bad++; $display("FAIL rst_mid got %h/%h/%h want 00400000/0/0", status_o, epc_o, cause_o);
    end
    rst = 0;
  endtask

  initial begin
    test_reset;
    test_syscall;
    test_ades_eret;
    test_interrupt;
    test_timer;
    test_stall;
    test_priority;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cp0_exception_unit.md
Name: cp0_exception_unit

Overview:
- MEM-stage exception arbiter and CP0 register file for the pipelined MIPS core.
- Consumes the per-instruction exception and CP0 control bits that the main decoder delivers in MEM (ri, break, syscall, eret, cp0 write, cp0-to-reg), plus datapath faults and hardware interrupts.
- Produces a pipeline flush and redirect PC, and holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Serves mfc0 reads for the writeback mux.

Parameters:
- EXC_ENTRY, 32'hBFC0_0380, redirect PC for every exception except eret.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- stallM  in  1  MEM stage held; no exception commit this cycle
- validM  in  1  MEM holds a real instruction (not a bubble)
- riM, breakM, syscallM, eretM  in  1 each  decoder exception bits
- overflowM  in  1  ALU signed overflow
- adel_fetchM  in  1  instruction fetch address misaligned
- adel_dataM, ades_dataM  in  1 each  load / store address misaligned
- in_delayslotM  in  1  MEM instruction sits in a branch delay slot
- pcM  in  32  PC of the MEM instruction
- mem_addrM  in  32  data address of the MEM instruction
- cp0_wenM  in  1  mtc0 write enable
- cp0_addrM  in  5  rd field; write address and mfc0 read address
- cp0_wdataM  in  32  mtc0 data (rt value)
- int_i  in  6  hardware interrupt lines, level-sensitive
- cp0_rdataM  out  32  combinational read of the addressed register
- exc_flush  out  1  flush IF–MEM and redirect fetch
- exc_pc  out  32  redirect target
- exc_code  out  5  ExcCode of the exception taken this cycle
- epc_o, status_o, cause_o  out  32 each  current register values
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Registers and reset values:
  - BadVAddr (8) = 0.
  - Count (9) = 0.
  - Compare (11) = 0.
  - Status (12) = 32'h0040_0000. BEV (bit 22) is 1 and read-only. Writable bits: IM[15:8], EXL[1], IE[0]. All other bits read 0.
  - Cause (13) = 0. Writable bits: IP[9:8] only. IP[15:10] = {int_i[5] | timer_int, int_i[4:0]}, sampled every cycle. BD is bit 31; ExcCode is [6:2].
  - EPC (14) = 0.
  - timer_int = 0.
  - Unimplemented addresses read 0 and ignore writes.
- Read: cp0_rdataM is combinational from the current register values. An mtc0 becomes visible on the next cycle; the datapath forwards same-cycle writes.
- Timer:
  - A one-bit tick toggles every cycle; Count increments when tick = 1 (half clock rate) and wraps 0xFFFF_FFFF -> 0.
  - mtc0 Count overrides that cycle's increment.
  - timer_int is set when Count == Compare and Compare != 0. It stays set until mtc0 Compare, which clears it; that clear has priority over a same-cycle set.
- Interrupt pending: validM & IE & ~EXL & |(Cause.IP[15:8] & Status.IM).
- Arbitration is combinational and active only when validM & ~stallM. Priority, highest first:
  - interrupt 0x00
  - adel_fetch 0x04
  - ri 0x0A
  - syscall 0x08
  - break 0x09
  - overflow 0x0C
  - adel_data 0x04
  - ades_data 0x05
  - eret
- On an exception (not eret):
  - Same cycle: exc_flush = 1, exc_pc = EXC_ENTRY, exc_code set.
  - Next edge:
    - EXL <= 1.
    - Cause.ExcCode <= code.
    - If EXL was 0: EPC <= in_delayslotM ? pcM-4 : pcM, and BD <= in_delayslotM. If EXL was already 1, EPC and BD are unchanged.
    - BadVAddr <= pcM for AdEL-fetch, mem_addrM for AdEL/AdES-data.
- On eret (no higher-priority exception): exc_flush = 1, exc_pc = EPC, EXL <= 0 at the next edge. exc_code = 0 and Cause.ExcCode is unchanged.
- An mtc0 in the same cycle as a taken exception is discarded; the exception state update wins.
- When stallM = 1 or validM = 0: exc_flush = 0, exc_code = 0, and no exception state changes. Count, timer and IP sampling continue.
- Reset asserted mid-operation: all registers return to reset values at that edge. exc_flush is 0 while rst = 1.

Decomposition:
- Shared package cp0_defs holds:
  - register address constants (8, 9, 11, 12, 13, 14);
  - ExcCode constants;
  - Status/Cause bit positions;
  - EXC_ENTRY default.
- One sub-module, cp0_timer: tick, Count, Compare, timer_int, with write ports for Count and Compare.

Test Plan:
- Reset, then read 12 -> 32'h0040_0000. Read 13, 14, 9 -> 0. exc_flush = 0.
- syscallM = 1, pcM = 32'hBFC0_1000, in_delayslotM = 0 -> same cycle exc_flush = 1, exc_pc = BFC0_0380, exc_code = 0x08. Next cycle EPC = BFC0_1000, Status.EXL = 1.
- ades_dataM, in_delayslotM = 1, pcM = 32'h8000_0024, mem_addrM = 32'h8000_1001 -> EPC = 8000_0020, Cause.BD = 1, BadVAddr = 8000_1001, ExcCode = 0x05. A subsequent eretM -> exc_pc = 8000_0020 and EXL = 0.
- mtc0 Status = 32'h0000_0401, then int_i[0] = 1 with validM = 1 and riM = 1 the same cycle -> exc_code = 0x00, not RI. A concurrent mtc0 Compare in that cycle is discarded.
- mtc0 Compare = 10 with Count = 0 -> timer_int_o rises after Count reaches 10 (about 20 cycles). Cause.IP[15] = 1. mtc0 Compare = 50 clears it the next cycle.
- stallM = 1 with breakM = 1 for 3 cycles -> exc_flush = 0 throughout. On the first cycle stallM drops, the exception is taken exactly once with exc_code = 0x09.
